sargantana_itag_ctrl: RTL and testbench
=======================================

# sargantana_itag_ctrl

Controller for the per-way instruction-cache tag array. It shares the single tag-array port between three requesters, in fixed priority: flush sweep, refill write, then lookup. It registers lookup metadata so it can compare tags when the synchronous tag read returns. It also selects refill victims round-robin and performs a full invalidation sweep after reset and on request. It sits between the icache front-end/refill logic and `sargantana_itag_memory`.

## Interface
Parameters:
- ICACHE_N_WAY, 4: number of ways.
- TAG_DEPTH, 64: sets per way.
- TAG_ADDR_WIDHT, $clog2(TAG_DEPTH): set index width.
- TAG_WIDHT, 20: tag width.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset, synchronous, active-high.
- flush_i, in, 1: request an invalidation of the whole array.
- flush_busy_o, out, 1: sweep in progress.
- flush_done_o, out, 1: one-cycle pulse when the last set of the sweep is written.
- lookup_valid_i / lookup_ready_o, in / out, 1 / 1: lookup handshake.
- lookup_idx_i, in, TAG_ADDR_WIDHT: set index of the lookup.
- lookup_tag_i, in, TAG_WIDHT: tag to compare.
- resp_valid_o, out, 1: lookup result valid.
- resp_hit_o, out, 1: OR of resp_way_o.
- resp_way_o, out, ICACHE_N_WAY: ways whose valid tag matched.
- refill_valid_i / refill_ready_o, in / out, 1 / 1: refill handshake.
- refill_idx_i, in, TAG_ADDR_WIDHT: set index to write.
- refill_tag_i, in, TAG_WIDHT: tag to write.
- refill_way_o, out, ICACHE_N_WAY: one-hot victim way; meaningful while refill_ready_o=1.
- tag_req_o, out, ICACHE_N_WAY: tag-array way enables.
- tag_we_o, out, 1: tag-array write enable.
- tag_vbit_o, out, 1: valid bit to write.
- tag_flush_o, out, 1: tag-array flush input; tied to 0.
- tag_data_o, out, TAG_WIDHT: tag to write.
- tag_addr_o, out, TAG_ADDR_WIDHT: set index.
- tag_way_i, in, ICACHE_N_WAY×TAG_WIDHT: tags read back, one per way.
- tag_vbit_i, in, ICACHE_N_WAY: valid bits read back, one per way.

## Operation
- FSM has two states, IDLE and FLUSH. The synchronous rst_i forces FLUSH with the sweep counter at 0 and the victim pointer at 0, and clears the pending-response flag.
- Values during and immediately after reset:
  - lookup_ready_o=0, refill_ready_o=0.
  - resp_valid_o=0, flush_done_o=0.
  - flush_busy_o=1.
- FLUSH behaviour:
  - Each cycle drive tag_req_o=all-ones, tag_we_o=1, tag_vbit_o=0, tag_data_o=0, tag_addr_o=counter.
  - Increment the counter each cycle.
  - At counter==TAG_DEPTH-1: pulse flush_done_o in that cycle, then go to IDLE the next cycle.
  - Both ready outputs are 0 for the whole sweep.
- flush_i in IDLE: go to FLUSH with counter=0. flush_i during FLUSH restarts the counter at 0 and does not pulse flush_done_o for the aborted sweep.
- IDLE priority: flush_i, then refill, then lookup.
  - refill_ready_o = !flush_i.
  - lookup_ready_o = !flush_i && !refill_valid_i.
- Refill accept (valid&ready):
  - Drive tag_req_o=refill_way_o, tag_we_o=1, tag_vbit_o=1, tag_data_o=refill_tag_i, tag_addr_o=refill_idx_i.
  - The victim pointer advances modulo ICACHE_N_WAY.
  - No response is generated.
- Lookup accept:
  - Drive tag_req_o=all-ones, tag_we_o=0, tag_addr_o=lookup_idx_i.
  - Register lookup_tag_i and set the pending flag.
- Lookup response, one cycle after accept:
  - resp_way_o[w] = tag_vbit_i[w] && (tag_way_i[w]==registered tag).
  - resp_valid_o=1 for exactly one cycle.
- No backpressure on responses. The consumer must accept in the cycle resp_valid_o is high.
- Multiple matching ways are reported as-is. Uniqueness is maintained by the refill logic and is not enforced here.

## Timing
- Lookup latency is 1 cycle, accept to resp_valid_o. Throughput is one lookup per cycle.
- Refill is written in the accept cycle. It is visible to lookups accepted in the following cycle or later.
- A response due in cycle N+1 is still delivered if a refill or flush is accepted in N+1. It reflects the array contents read in cycle N.
- A response pending at the cycle rst_i is asserted is dropped: resp_valid_o=0 in the following cycle.
- Sweep duration is TAG_DEPTH cycles. flush_busy_o falls the cycle after flush_done_o.
- All outputs toward the tag array are combinational from the state, the counter and the requester inputs. Response outputs are registered compare inputs plus combinational compare logic.

## Structure
- Shared package `sargantana_icache_pkg` holds:
  - typedef `itag_ctrl_state_t` {IDLE, FLUSH};
  - the way one-hot type, parameterized by ICACHE_N_WAY at the package level.
- One natural sub-module: `sargantana_icache_rr_victim`, the round-robin pointer with an advance enable and one-hot output.

## Test plan
- Reset release → flush_busy_o=1 for 64 cycles with tag_addr_o stepping 0..63. flush_done_o pulses with addr 63. lookup_ready_o=1 on cycle 65.
- Refill idx 5, tag 0xABCDE; then lookup idx 5, tag 0xABCDE → resp_valid_o one cycle later, resp_hit_o=1, resp_way_o=4'b0001. Lookup with tag 0xABCDF → resp_hit_o=0.
- Four refills to idx 9 → refill_way_o = 0001, 0010, 0100, 1000. Fifth refill → 0001.
- refill_valid_i and lookup_valid_i asserted together → refill written, lookup_ready_o=0. Lookup is accepted the next cycle and its response arrives one cycle after that.
- flush_i at sweep counter 30 → counter restarts at 0 and no flush_done_o pulse at 30. Sweep completes 64 cycles after the restart. A lookup to a previously refilled set then misses.
- rst_i asserted the cycle after a lookup accept → resp_valid_o=0 the next cycle and the FSM is in FLUSH.

Source files
------------

// File: rtl/sargantana_icache_pkg.sv
// Shared types for the instruction-cache tag path: controller FSM states and
// the per-way one-hot vector type.
package sargantana_icache_pkg;

    localparam int unsigned ICACHE_N_WAY = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } itag_ctrl_state_t;

    typedef logic [ICACHE_N_WAY-1:0] icache_way_t;

endpackage

// File: rtl/sargantana_icache_rr_victim.sv
// Round-robin refill victim pointer held as a one-hot vector; rotates one way
// each cycle advance_i is high.
module sargantana_icache_rr_victim
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned N_WAY = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             advance_i,
    output logic [N_WAY-1:0] way_o
);

    logic [N_WAY-1:0] ptr_reg;
    logic [N_WAY-1:0] ptr_rot;
    logic [N_WAY-1:0] ptr_next;

    genvar gi;
    generate
        for (gi = 0; gi < N_WAY; gi++) begin : g_rot
            assign ptr_rot[gi] = ptr_reg[(gi + N_WAY - 1) % N_WAY];
        end
    endgenerate

    always_comb begin
        ptr_next = ptr_reg;
        if (advance_i) begin
            ptr_next = ptr_rot;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_reg <= {{(N_WAY-1){1'b0}}, 1'b1};
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign way_o = ptr_reg;

endmodule

// File: rtl/sargantana_itag_ctrl.sv
// Arbitrates the single tag-array port between flush sweep, refill write and
// lookup, and compares the returned tags one cycle after a lookup is accepted.
module sargantana_itag_ctrl #(
    parameter int unsigned ICACHE_N_WAY   = 4,
    parameter int unsigned TAG_DEPTH      = 64,
    parameter int unsigned TAG_ADDR_WIDHT = $clog2(TAG_DEPTH),
    parameter int unsigned TAG_WIDHT      = 20
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    output logic                              flush_busy_o,
    output logic                              flush_done_o,
    input  logic                              lookup_valid_i,
    output logic                              lookup_ready_o,
    input  logic [TAG_ADDR_WIDHT-1:0]         lookup_idx_i,
    input  logic [TAG_WIDHT-1:0]              lookup_tag_i,
    output logic                              resp_valid_o,
    output logic                              resp_hit_o,
    output logic [ICACHE_N_WAY-1:0]           resp_way_o,
    input  logic                              refill_valid_i,
    output logic                              refill_ready_o,
    input  logic [TAG_ADDR_WIDHT-1:0]         refill_idx_i,
    input  logic [TAG_WIDHT-1:0]              refill_tag_i,
    output logic [ICACHE_N_WAY-1:0]           refill_way_o,
    output logic [ICACHE_N_WAY-1:0]           tag_req_o,
    output logic                              tag_we_o,
    output logic                              tag_vbit_o,
    output logic                              tag_flush_o,
    output logic [TAG_WIDHT-1:0]              tag_data_o,
    output logic [TAG_ADDR_WIDHT-1:0]         tag_addr_o,
    input  logic [ICACHE_N_WAY*TAG_WIDHT-1:0] tag_way_i,
    input  logic [ICACHE_N_WAY-1:0]           tag_vbit_i
);

    import sargantana_icache_pkg::*;

    localparam logic [TAG_ADDR_WIDHT-1:0] LAST_SET = TAG_ADDR_WIDHT'(TAG_DEPTH - 1);

    itag_ctrl_state_t          state_reg, state_next;
    logic [TAG_ADDR_WIDHT-1:0] cnt_reg, cnt_next;
    logic                      resp_pending_reg;
    logic [TAG_WIDHT-1:0]      tag_q_reg;
    logic                      refill_acc;
    logic                      lookup_acc;

    sargantana_icache_rr_victim #(
        .N_WAY (ICACHE_N_WAY)
    ) u_rr_victim (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .advance_i (refill_acc),
        .way_o     (refill_way_o)
    );

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        flush_done_o   = 1'b0;
        refill_ready_o = 1'b0;
        lookup_ready_o = 1'b0;
        refill_acc     = 1'b0;
        lookup_acc     = 1'b0;
        tag_req_o      = '0;
        tag_we_o       = 1'b0;
        tag_vbit_o     = 1'b0;
        tag_data_o     = '0;
        tag_addr_o     = lookup_idx_i;

        case (state_reg)
            FLUSH: begin
                tag_req_o  = '1;
                tag_we_o   = 1'b1;
                tag_addr_o = cnt_reg;
                // A new request aborts the sweep silently and starts over.
                if (flush_i) begin
                    cnt_next = '0;
                end else if (cnt_reg == LAST_SET) begin
                    flush_done_o = 1'b1;
                    state_next   = IDLE;
                    cnt_next     = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                refill_ready_o = !flush_i && !rst_i;
                lookup_ready_o = !flush_i && !refill_valid_i && !rst_i;
                refill_acc     = refill_valid_i && refill_ready_o;
                lookup_acc     = lookup_valid_i && lookup_ready_o;
                if (flush_i) begin
                    state_next = FLUSH;
                    cnt_next   = '0;
                end
                if (refill_acc) begin
                    tag_req_o  = refill_way_o;
                    tag_we_o   = 1'b1;
                    tag_vbit_o = 1'b1;
                    tag_data_o = refill_tag_i;
                    tag_addr_o = refill_idx_i;
                end else if (lookup_acc) begin
                    tag_req_o  = '1;
                    tag_addr_o = lookup_idx_i;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg        <= FLUSH;
            cnt_reg          <= '0;
            resp_pending_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            resp_pending_reg <= lookup_acc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (lookup_acc) begin
            tag_q_reg <= lookup_tag_i;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ICACHE_N_WAY; gi++) begin : g_cmp
            assign resp_way_o[gi] = resp_pending_reg && tag_vbit_i[gi] &&
                                    (tag_way_i[gi*TAG_WIDHT +: TAG_WIDHT] == tag_q_reg);
        end
    endgenerate

    assign resp_valid_o = resp_pending_reg;
    assign resp_hit_o   = |resp_way_o;
    assign flush_busy_o = (state_reg == FLUSH);
    assign tag_flush_o  = 1'b0;

endmodule

// File: tb/tb_sargantana_itag_ctrl.sv
// Bench for sargantana_itag_ctrl: a behavioural tag memory feeds the DUT and
// a set/way reference model predicts readiness, victims and lookup results.
module tb_sargantana_itag_ctrl;

    localparam int NW    = 4;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int TW    = 20;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          flush_i;
    logic          flush_busy_o;
    logic          flush_done_o;
    logic          lookup_valid_i;
    logic          lookup_ready_o;
    logic [AW-1:0] lookup_idx_i;
    logic [TW-1:0] lookup_tag_i;
    logic          resp_valid_o;
    logic          resp_hit_o;
    logic [NW-1:0] resp_way_o;
    logic          refill_valid_i;
    logic          refill_ready_o;
    logic [AW-1:0] refill_idx_i;
    logic [TW-1:0] refill_tag_i;
    logic [NW-1:0] refill_way_o;
    logic [NW-1:0] tag_req_o;
    logic          tag_we_o;
    logic          tag_vbit_o;
    logic          tag_flush_o;
    logic [TW-1:0] tag_data_o;
    logic [AW-1:0] tag_addr_o;
    logic [NW*TW-1:0] tag_way_i;
    logic [NW-1:0] tag_vbit_i;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    sargantana_itag_ctrl #(
        .ICACHE_N_WAY   (NW),
        .TAG_DEPTH      (DEPTH),
        .TAG_ADDR_WIDHT (AW),
        .TAG_WIDHT      (TW)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .flush_busy_o   (flush_busy_o),
        .flush_done_o   (flush_done_o),
        .lookup_valid_i (lookup_valid_i),
        .lookup_ready_o (lookup_ready_o),
        .lookup_idx_i   (lookup_idx_i),
        .lookup_tag_i   (lookup_tag_i),
        .resp_valid_o   (resp_valid_o),
        .resp_hit_o     (resp_hit_o),
        .resp_way_o     (resp_way_o),
        .refill_valid_i (refill_valid_i),
        .refill_ready_o (refill_ready_o),
        .refill_idx_i   (refill_idx_i),
        .refill_tag_i   (refill_tag_i),
        .refill_way_o   (refill_way_o),
        .tag_req_o      (tag_req_o),
        .tag_we_o       (tag_we_o),
        .tag_vbit_o     (tag_vbit_o),
        .tag_flush_o    (tag_flush_o),
        .tag_data_o     (tag_data_o),
        .tag_addr_o     (tag_addr_o),
        .tag_way_i      (tag_way_i),
        .tag_vbit_i     (tag_vbit_i)
    );

    // Behavioural tag memory: synchronous write and registered read per way.
    logic [TW-1:0] mem_tag [NW][DEPTH];
    logic          mem_v   [NW][DEPTH];

    initial begin
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < DEPTH; s++) begin
                mem_tag[w][s] = '0;
                mem_v[w][s]   = 1'b0;
            end
        tag_way_i  = '0;
        tag_vbit_i = '0;
    end

    always @(posedge clk_i) begin
        for (int w = 0; w < NW; w++) begin
            if (tag_req_o[w]) begin
                if (tag_we_o) begin
                    mem_tag[w][tag_addr_o] <= tag_data_o;
                    mem_v[w][tag_addr_o]   <= tag_vbit_o;
                end else begin
                    tag_way_i[w*TW +: TW] <= mem_tag[w][tag_addr_o];
                    tag_vbit_i[w]         <= mem_v[w][tag_addr_o];
                end
            end
        end
    end

    // Reference model of cache contents and victim choice.
    bit      ref_v [NW][DEPTH];
    int      ref_t [NW][DEPTH];
    int      victim;

    task automatic ref_clear();
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < DEPTH; s++)
                ref_v[w][s] = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        rst_i          = 1'b0;
        flush_i        = 1'b0;
        refill_valid_i = 1'b0;
        lookup_valid_i = 1'b0;
        refill_idx_i   = '0;
        refill_tag_i   = '0;
        lookup_idx_i   = '0;
        lookup_tag_i   = '0;
    endtask

    // One IDLE-state cycle with arbitrary requests; checks everything the model predicts.
    task automatic cycle(input bit rv, input int ri, input int rt,
                         input bit lv, input int li, input int lt, input bit fl);
        bit            exp_rr, exp_lr, racc, lacc;
        logic [NW-1:0] exp_way;
        @(negedge clk_i);
        drive_idle();
        flush_i        = fl;
        refill_valid_i = rv;
        refill_idx_i   = AW'(ri);
        refill_tag_i   = TW'(rt);
        lookup_valid_i = lv;
        lookup_idx_i   = AW'(li);
        lookup_tag_i   = TW'(lt);
        #1;
        exp_rr = !fl;
        exp_lr = !fl && !rv;
        racc   = rv && exp_rr;
        lacc   = lv && exp_lr;
        chk("busy_idle", flush_busy_o, 0);
        chk("refill_ready", refill_ready_o, exp_rr);
        chk("lookup_ready", lookup_ready_o, exp_lr);
        if (racc) begin
            chk("refill_way", refill_way_o, 32'(1 << victim));
            chk("refill_we", tag_we_o, 1);
            chk("refill_addr", tag_addr_o, ri);
            chk("refill_data", tag_data_o, rt);
        end
        exp_way = '0;
        for (int w = 0; w < NW; w++)
            exp_way[w] = ref_v[w][li] && (ref_t[w][li] == lt);
        @(posedge clk_i);
        if (racc) begin
            ref_v[victim][ri] = 1'b1;
            ref_t[victim][ri] = rt;
            victim = (victim + 1) % NW;
        end
        #1;
        chk("resp_valid", resp_valid_o, lacc);
        if (lacc) begin
            chk("resp_way", resp_way_o, exp_way);
            chk("resp_hit", resp_hit_o, |exp_way);
        end
        $display("cycle rv=%0d idx=%0d tag=%0h lv=%0d idx=%0d tag=%0h fl=%0d resp=%0d way=%b",
                 rv, ri, rt, lv, li, lt, fl, resp_valid_o, resp_way_o);
    endtask

    // Follows a sweep from counter 0; optionally re-requests a flush at abort_at.
    task automatic run_sweep(input int abort_at);
        int k;
        bit aborted;
        bit finished;
        k        = 0;
        aborted  = 1'b0;
        finished = 1'b0;
        for (int n = 0; n < 3 * DEPTH; n++) begin
            @(negedge clk_i);
            drive_idle();
            flush_i = (!aborted && k == abort_at);
            #1;
            chk("sweep_busy", flush_busy_o, 1);
            chk("sweep_addr", tag_addr_o, k);
            chk("sweep_we", {tag_req_o, tag_we_o, tag_vbit_o}, {{NW{1'b1}}, 2'b10});
            chk("sweep_done", flush_done_o, (k == DEPTH - 1) && !flush_i);
            chk("sweep_ready", {refill_ready_o, lookup_ready_o}, 0);
            @(posedge clk_i);
            if (flush_i) begin
                k = 0;
                aborted = 1'b1;
            end else if (k == DEPTH - 1) begin
                finished = 1'b1;
                break;
            end else begin
                k++;
            end
        end
        chk("sweep_finished", finished, 1);
        ref_clear();
        @(negedge clk_i);
        drive_idle();
        #1;
        chk("post_sweep_busy", flush_busy_o, 0);
        chk("post_sweep_lookup_ready", lookup_ready_o, 1);
        $display("sweep abort_at=%0d finished=%0d", abort_at, finished);
    endtask

    initial begin
        drive_idle();
        rst_i  = 1'b1;
        victim = 0;
        ref_clear();
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < DEPTH; s++)
                ref_t[w][s] = 0;

        // Reset held: sweep pending, no handshakes, no response.
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_busy", flush_busy_o, 1);
        chk("rst_ready", {refill_ready_o, lookup_ready_o}, 0);
        chk("rst_resp", resp_valid_o, 0);
        chk("rst_done", flush_done_o, 0);
        chk("tag_flush", tag_flush_o, 0);
        run_sweep(-1);

        // Refill then hit / miss lookups.
        cycle(1, 5, 'hABCDE, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 5, 'hABCDE, 0);
        cycle(0, 0, 0, 1, 5, 'hABCDF, 0);

        // Fill all ways of set 9 plus one wrap-around.
        for (int i = 0; i < 5; i++)
            cycle(1, 9, 'h900 + i, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            cycle(0, 0, 0, 1, 9, 'h900 + i, 0);

        // Refill and lookup together: refill wins, lookup follows.
        cycle(1, 12, 'h123, 1, 12, 'h123, 0);
        cycle(0, 0, 0, 1, 12, 'h123, 0);

        // Back-to-back lookups then randomized traffic.
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 7), 'h100 + $urandom_range(0, 3),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7), 'h100 + $urandom_range(0, 3), 0);

        // Flush request, aborted mid-sweep at 30, then previously valid set misses.
        cycle(1, 5, 'hABCDE, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 5, 'hABCDE, 0);
        cycle(0, 0, 0, 1, 5, 0, 1);
        run_sweep(30);
        cycle(0, 0, 0, 1, 5, 'hABCDE, 0);

        // Reset while a response is pending drops it.
        @(negedge clk_i);
        drive_idle();
        lookup_valid_i = 1'b1;
        lookup_idx_i   = AW'(5);
        @(negedge clk_i);
        drive_idle();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_drop_resp", resp_valid_o, 0);
        chk("rst_drop_busy", flush_busy_o, 1);
        victim = 0;
        run_sweep(-1);
        cycle(1, 3, 'h55, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 3, 'h55, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $fatal(1, "FAIL timeout");
    end

endmodule
